// File: rtl/button_sched_pkg.sv
// Shared types, constants and the round-robin search helper for button_event_scheduler.
// Slot indices are 4 bits wide so one helper covers up to 16 arbitration slots.
package button_sched_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SEND = 1'b1;

  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] REL_FLAG = 8'h80;

  localparam int MAX_SLOTS  = 16;
  localparam int SLOT_IDX_W = 4;

  // First set bit of req[n-1:0], searching upward from ptr and wrapping at n.
  function automatic logic [SLOT_IDX_W-1:0] rr_first(
    input logic [MAX_SLOTS-1:0]  req,
    input logic [SLOT_IDX_W-1:0] ptr,
    input int                    n
  );
    logic [SLOT_IDX_W-1:0] idx;
    logic                  found;
    int                    pos;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_SLOTS; k++) begin
      if (k < n) begin
        pos = int'(ptr) + k;
        if (pos >= n) pos = pos - n;
        if (!found && req[SLOT_IDX_W'(pos)]) begin
          idx   = SLOT_IDX_W'(pos);
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Key-code handshake towards the UART transmit path; the scheduler drives the master side.
interface button_event_scheduler_if;
  import button_sched_pkg::*;

  logic [CODE_W-1:0] oCode;
  logic              oValid;
  logic              iReady;

  modport master (output oCode, output oValid, input iReady);
  modport slave  (input oCode, input oValid, output iReady);
endinterface

// File: rtl/button_sample_filter.sv
// Per-button 2-flop synchroniser, tick-sampled history and debounced level.
// deb_next_o exposes the level the debounced flop takes on the coming edge.
module button_sample_filter #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic tick_i,
  input  logic raw_i,
  output logic deb_o,
  output logic deb_next_o
);

  logic                      sync1_q;
  logic                      sync2_q;
  logic [STABLE_SAMPLES-1:0] hist_q;
  logic [STABLE_SAMPLES-1:0] hist_d;
  logic                      deb_q;
  logic                      deb_d;

  always_comb begin
    hist_d = hist_q;
    deb_d  = deb_q;
    if (tick_i) begin
      hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q};
      // Level only changes when every sample in the window agrees.
      if (&hist_d) begin
        deb_d = 1'b1;
      end else if (~|hist_d) begin
        deb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o      = deb_q;
  assign deb_next_o = deb_d;

endmodule

// File: rtl/button_event_scheduler.sv
// Shared-tick button debouncer that turns press events into key codes for UART TX.
// Define BUTTON_SCHED_RELEASE_EN to also emit release codes (code | 8'h80).
module button_event_scheduler
  import button_sched_pkg::*;
#(
  parameter int                N_BUTTONS      = 4,
  parameter int                TICK_DIV       = 500000,
  parameter int                STABLE_SAMPLES = 3,
  parameter logic [CODE_W-1:0] CODE_BASE      = 8'h31
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [N_BUTTONS-1:0]   iButtons,
  output logic [N_BUTTONS-1:0]   oDebounced,
  output logic                   oDrop,
  button_event_scheduler_if.master tx
);

  localparam int TW = $clog2(TICK_DIV);

`ifdef BUTTON_SCHED_RELEASE_EN
  localparam int N_SLOTS = 2 * N_BUTTONS;
`else
  localparam int N_SLOTS = N_BUTTONS;
`endif

  logic [TW-1:0]         tick_cnt_q;
  logic [TW-1:0]         tick_cnt_d;
  logic                  tick;
  logic [N_BUTTONS-1:0]  deb;
  logic [N_BUTTONS-1:0]  deb_next;
  logic [N_SLOTS-1:0]    ev;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_filter
      button_sample_filter #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_filter (
        .clk       (iClk),
        .srst      (iRst),
        .tick_i    (tick),
        .raw_i     (iButtons[gi]),
        .deb_o     (deb[gi]),
        .deb_next_o(deb_next[gi])
      );
`ifdef BUTTON_SCHED_RELEASE_EN
      // Press slot 2i sits just ahead of release slot 2i+1 in the pointer space.
      assign ev[2*gi]   = deb_next[gi] & ~deb[gi];
      assign ev[2*gi+1] = ~deb_next[gi] & deb[gi];
`else
      assign ev[gi] = deb_next[gi] & ~deb[gi];
`endif
    end
  endgenerate

  assign oDebounced = deb;

  function automatic logic [CODE_W-1:0] slot_code(input logic [SLOT_IDX_W-1:0] slot);
    logic [CODE_W-1:0] code;
`ifdef BUTTON_SCHED_RELEASE_EN
    code = CODE_BASE + CODE_W'(slot >> 1);
    if (slot[0]) code = code | REL_FLAG;
`else
    code = CODE_BASE + CODE_W'(slot);
`endif
    return code;
  endfunction

  state_t                  state_q;
  state_t                  state_d;
  logic [N_SLOTS-1:0]      pend_q;
  logic [N_SLOTS-1:0]      pend_d;
  logic [SLOT_IDX_W-1:0]   ptr_q;
  logic [SLOT_IDX_W-1:0]   ptr_d;
  logic [CODE_W-1:0]       code_q;
  logic [CODE_W-1:0]       code_d;
  logic                    valid_q;
  logic                    valid_d;
  logic                    drop_q;
  logic                    drop_d;
  logic [SLOT_IDX_W-1:0]   grant_idx;
  logic                    grant;

  always_comb begin
    grant_idx = rr_first(MAX_SLOTS'(pend_q), ptr_q, N_SLOTS);
    grant     = (state_q == ST_IDLE) && (|pend_q);
    state_d   = state_q;
    pend_d    = pend_q;
    ptr_d     = ptr_q;
    code_d    = code_q;
    valid_d   = valid_q;
    drop_d    = 1'b0;

    // A new event on the slot being granted re-arms it rather than dropping.
    for (int s = 0; s < N_SLOTS; s++) begin
      if (grant && grant_idx == SLOT_IDX_W'(s)) begin
        pend_d[s] = 1'b0;
      end
      if (ev[s]) begin
        if (pend_q[s] && !(grant && grant_idx == SLOT_IDX_W'(s))) begin
          drop_d = 1'b1;
        end else begin
          pend_d[s] = 1'b1;
        end
      end
    end

    if (state_q == ST_IDLE) begin
      if (grant) begin
        code_d  = slot_code(grant_idx);
        valid_d = 1'b1;
        ptr_d   = (grant_idx == SLOT_IDX_W'(N_SLOTS - 1)) ? '0 : grant_idx + 1'b1;
        state_d = ST_SEND;
      end
    end else begin
      if (tx.iReady) begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tick_cnt_q <= '0;
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      ptr_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  assign tx.oCode  = code_q;
  assign tx.oValid = valid_q;
  assign oDrop     = drop_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Table-driven and scenario bench for button_event_scheduler with a code scoreboard.
module tb_button_event_scheduler;

  localparam logic [7:0] BASE = 8'h31;
`ifdef BUTTON_SCHED_RELEASE_EN
  localparam int REL = 1;
`else
  localparam int REL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttons = 4'h0;
  logic [3:0] deb;
  logic       drop;

  button_event_scheduler_if tx_if ();

  button_event_scheduler #(
    .N_BUTTONS     (4),
    .TICK_DIV      (4),
    .STABLE_SAMPLES(3),
    .CODE_BASE     (8'h31)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iButtons  (buttons),
    .oDebounced(deb),
    .oDrop     (drop),
    .tx        (tx_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  int         drop_count = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] held_code = 8'h00;
  logic [7:0] exp_code;

  typedef struct {
    logic [3:0]       mask;
    int               n;
    logic [3:0][7:0]  codes;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input logic [3:0] m, input int n,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
    vec_t v;
    v.mask     = m;
    v.n        = n;
    v.codes[0] = c0;
    v.codes[1] = c1;
    v.codes[2] = c2;
    v.codes[3] = c3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake monitor: scoreboard pop on every accepted code, stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (drop) drop_count++;
      if (hold_pending && tx_if.oValid) check("hold_stable", 32'(tx_if.oCode), 32'(held_code));
      if (tx_if.oValid && tx_if.iReady) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_code: got %02h expected none", tx_if.oCode);
        end else begin
          exp_code = sb.pop_front();
          $display("XFER code=%02h expected=%02h", tx_if.oCode, exp_code);
          check("code", 32'(tx_if.oCode), 32'(exp_code));
        end
      end
      hold_pending = tx_if.oValid && !tx_if.iReady;
      held_code    = tx_if.oCode;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      cyc();
      t++;
    end
    check(name, 32'(sb.size()), 32'd0);
    cyc(2);
  endtask

  task automatic wait_deb(input int b, input logic lvl, input string name);
    int t = 0;
    while (deb[b] !== lvl && t < 60) begin
      cyc();
      t++;
    end
    check(name, 32'(deb[b]), 32'(lvl));
  endtask

  task automatic release_btn(input int b);
    buttons[b] = 1'b0;
    if (REL != 0) sb.push_back((BASE + 8'(b)) | 8'h80);
    wait_deb(b, 1'b0, "release_deb");
    wait_drain("release_drain", 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int b;

    tbl[0] = mk(4'b1011, 3, 8'h31, 8'h32, 8'h34, 8'h00);
    tbl[1] = mk(4'b1001, 2, 8'h31, 8'h34, 8'h00, 8'h00);
    tbl[2] = mk(4'b0100, 1, 8'h33, 8'h00, 8'h00, 8'h00);
    tbl[3] = mk(4'b0011, 2, 8'h31, 8'h32, 8'h00, 8'h00);
    tbl[4] = mk(4'b1111, 4, 8'h33, 8'h34, 8'h31, 8'h32);
    tbl[5] = mk(4'b1000, 1, 8'h34, 8'h00, 8'h00, 8'h00);

    // Reset held with all buttons pressed, then exact debounce/grant timing.
    rst = 1'b1;
    buttons = 4'hF;
    tx_if.iReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("rst_valid", 32'(tx_if.oValid), 32'd0);
      check("rst_code", 32'(tx_if.oCode), 32'd0);
      check("rst_deb", 32'(deb), 32'd0);
      check("rst_drop", 32'(drop), 32'd0);
    end
    rst = 1'b0;
    sb.push_back(8'h31);
    sb.push_back(8'h32);
    sb.push_back(8'h33);
    sb.push_back(8'h34);
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (c <= 12) check("post_rst_no_valid", 32'(tx_if.oValid), 32'd0);
      if (c == 11) check("deb_before_3rd_tick", 32'(deb), 32'h0);
      if (c == 12) check("deb_on_3rd_tick", 32'(deb), 32'hF);
      if (c == 13) begin
        check("first_valid", 32'(tx_if.oValid), 32'd1);
        check("first_code", 32'(tx_if.oCode), 32'h31);
      end
    end
    wait_drain("reset_burst_drain", 100);
    for (int i = 0; i < 4; i++) release_btn(i);

    // Table of simultaneous presses; releases follow grant order.
    for (int i = 0; i < 6; i++) begin
      buttons = tbl[i].mask;
      for (int k = 0; k < tbl[i].n; k++) sb.push_back(tbl[i].codes[k]);
      wait_drain($sformatf("vec%0d_drain", i), 200);
      check($sformatf("vec%0d_deb", i), 32'(deb), 32'(tbl[i].mask));
      for (int k = 0; k < tbl[i].n; k++) begin
        b = int'(tbl[i].codes[k] - BASE);
        release_btn(b);
      end
    end

    // Single press with a stalled receiver.
    tx_if.iReady = 1'b0;
    buttons[2] = 1'b1;
    sb.push_back(8'h33);
    wait_deb(2, 1'b1, "single_deb");
    check("single_valid_lat0", 32'(tx_if.oValid), 32'd0);
    cyc();
    check("single_valid_lat1", 32'(tx_if.oValid), 32'd1);
    check("single_code", 32'(tx_if.oCode), 32'h33);
    for (int c = 0; c < 5; c++) begin
      cyc();
      check("stall_valid", 32'(tx_if.oValid), 32'd1);
      check("stall_code", 32'(tx_if.oCode), 32'h33);
    end
    tx_if.iReady = 1'b1;
    cyc();
    check("accept_valid_low", 32'(tx_if.oValid), 32'd0);
    check("single_sb_empty", 32'(sb.size()), 32'd0);
    release_btn(2);

    // Bounce: toggling every 3 cycles never gives 3 agreeing samples.
    for (int t = 0; t < 42; t++) begin
      buttons[0] = ((t / 3) % 2) == 0;
      cyc();
      check("bounce_deb", 32'(deb[0]), 32'd0);
    end
    buttons = 4'h0;
    cyc(20);
    check("bounce_deb_final", 32'(deb), 32'd0);

    // Overflow on button 1 with the first code held.
    tx_if.iReady = 1'b0;
    drop_count = 0;
    buttons[1] = 1'b1;
    sb.push_back(8'h32);
    wait_deb(1, 1'b1, "ovf_press1");
    cyc(2);
    check("ovf_held_valid", 32'(tx_if.oValid), 32'd1);
    check("ovf_held_code", 32'(tx_if.oCode), 32'h32);
    buttons[1] = 1'b0;
    wait_deb(1, 1'b0, "ovf_rel1");
    buttons[1] = 1'b1;
    wait_deb(1, 1'b1, "ovf_press2");
    cyc(2);
    check("ovf_no_drop_yet", 32'(drop_count), 32'd0);
    buttons[1] = 1'b0;
    wait_deb(1, 1'b0, "ovf_rel2");
    cyc(2);
    check("ovf_drop_after_rel2", 32'(drop_count), 32'(REL));
    buttons[1] = 1'b1;
    wait_deb(1, 1'b1, "ovf_press3");
    cyc(2);
    check("ovf_drop_count", 32'(drop_count), 32'(1 + REL));
    check("ovf_still_held", 32'(tx_if.oCode), 32'h32);

    // Reset while a code is held discards it and all pending events.
    rst = 1'b1;
    buttons = 4'h0;
    cyc();
    check("midrst_valid", 32'(tx_if.oValid), 32'd0);
    check("midrst_code", 32'(tx_if.oCode), 32'd0);
    check("midrst_deb", 32'(deb), 32'd0);
    sb.delete();
    rst = 1'b0;
    tx_if.iReady = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (tx_if.oValid) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Shares one sample-tick generator across N_BUTTONS raw push-buttons and debounces each one by stable-sample counting.
- Converts debounced press events into single-byte key codes.
- Serialises those codes to the UART transmit path through a round-robin arbiter and a valid/ready handshake.
- Sits between the board buttons and the uart_keyboard transmit datapath, replacing per-button free-running debouncers.

Parameters:
- N_BUTTONS, 4, number of button inputs (1..8).
- TICK_DIV, 500000, clock cycles per sample tick (10 ms at 50 MHz); minimum 2.
- STABLE_SAMPLES, 3, consecutive identical samples required to change debounced state (2..8).
- CODE_BASE, 8'h31, key code of button 0; button i emits CODE_BASE+i.

Ports:
- iClk  input  1  system clock.
- iRst  input  1  synchronous, active-high reset.
- iButtons  input  N_BUTTONS  raw asynchronous button levels, 1 = pressed.
- oCode  output  8  key code presented to UART TX.
- oValid  output  1  oCode valid; held until accepted.
- iReady  input  1  UART TX accepts oCode when oValid&iReady.
- oDebounced  output  N_BUTTONS  current debounced level per button.
- oDrop  output  1  one-cycle pulse when an event is lost because that button's event was still pending.

Behaviour:
- Interface is fixed: single clock iClk; reset iRst is synchronous and active-high, sampled only on posedge iClk.
- Reset values (all outputs): oCode=0, oValid=0, oDebounced=0, oDrop=0. Tick counter=0, pending=0, sample histories=0, arbiter pointer=0, FSM=IDLE.
- Input sync: each iButtons bit passes through a 2-flop synchroniser before use.
- Tick generator:
  - Counter runs 0..TICK_DIV-1, wraps to 0.
  - tick=1 for exactly the cycle where count==TICK_DIV-1.
- Sampling: on tick, each button shifts its synced level into a STABLE_SAMPLES-deep history.
- Debounce: if the whole history equals a value different from oDebounced[i], oDebounced[i] updates on the same edge as that shift.
- Events:
  - A 0->1 change of oDebounced[i] sets pending[i] on that same edge.
  - A 1->0 change creates no event (see optional feature).
- FSM states: IDLE, SEND.
  - IDLE, pending!=0: grant the first pending index searching from ptr upward, wrapping modulo N_BUTTONS.
  - On grant, the same edge sets oCode=CODE_BASE+idx, oValid=1, clears pending[idx], sets ptr=(idx+1) mod N_BUTTONS, and moves to SEND.
  - SEND: oValid and oCode stay stable until oValid&iReady; on that edge oValid=0 and FSM returns to IDLE.
  - Minimum one idle cycle between consecutive codes.
- Latency: with FSM idle and no other pending, oValid rises 1 cycle after the debounce edge.
- Simultaneous events:
  - Grant clearing pending[idx] on the same edge as a new event on idx: the set wins and pending stays 1.
  - Multiple new events on one edge all register.
- Overflow: new event on i while pending[i]=1 (and not being granted) -> event lost, oDrop=1 for one cycle.
- iReady while oValid=0 is ignored.
- Reset mid-operation: a held code is discarded and oValid is 0 after the reset edge. Debounce restarts from all-released.

Optional Feature:
- Macro: BUTTON_SCHED_RELEASE_EN.
- Defined:
  - 1->0 debounced changes also raise events, tracked in a separate release-pending vector.
  - Release codes are (CODE_BASE+i)|8'h80.
  - Arbitration runs over 2*N_BUTTONS slots: press slot i precedes release slot i, in one round-robin pointer space.
  - Drop rule applies per slot.
- Undefined: releases are silent and only press logic exists.

Decomposition:
- Package button_sched_pkg holds:
  - FSM state typedef (IDLE, SEND).
  - Code width constant (8).
  - Release flag constant 8'h80.
  - Helper function for the wrap-around first-set search.
- One natural sub-module: button_sample_filter. It contains the synchroniser, history and debounced state for one button, instantiated N_BUTTONS times. Tick generator and arbiter stay in the top.

Test Plan:
Bench parameters: TICK_DIV=4, STABLE_SAMPLES=3.
- Reset: hold iRst=1 for 3 cycles with iButtons=4'hF -> all outputs 0 throughout; no oValid for ≥10 cycles after release until 3 ticks elapse.
- Single press, iButtons[2]=1 steady:
  - oDebounced[2] rises on the 3rd tick edge.
  - oValid=1, oCode=8'h33 the next cycle.
  - iReady held 0 for 5 cycles -> oCode stable; iReady=1 -> oValid=0 next edge.
- Bounce: toggle iButtons[0] every 3 cycles for 40 cycles, then release -> oDebounced[0] stays 0, no oValid.
- Round-robin: buttons 0,1,3 pressed on the same tick, iReady=1 -> codes 8'h31, 8'h32, 8'h34 in order. Then ptr=0; pressing 3 then 0 together -> 8'h31 first.
- Overflow: iReady=0, press/release/press button 1 past debounce twice -> first code held; second press gives pending; third press gives oDrop pulse exactly once.
- Reset mid-SEND: iRst=1 while oValid=1 -> oValid=0 after that edge, pending cleared. With BUTTON_SCHED_RELEASE_EN, releasing button 2 -> oCode=8'hB3.
